// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//
// Multi-cycle multiply/divide unit with the architectural HI/LO registers
// for a MIPS-style EX stage. mult/multu run as a 32-step shift-add and
// div/divu as a 32-step restoring division. Both operate on operand
// magnitudes. Signs are applied once, in the FIN state, when HI/LO are
// written.
//
// Ports
//   clk      : single clock, rising edge
//   reset    : asynchronous, active-low reset
//   valid    : EX-stage instruction is R-type and not flushed
//   Funct    : EX-stage function field
//   rs_data  : forwarded rs operand
//   rt_data  : forwarded rt operand
//   stall    : freeze PC/IF-ID/ID-EX and bubble EX/MEM while a HI/LO
//              instruction waits on a running operation
//   busy     : an operation is in flight (state != IDLE)
//   done     : one-cycle pulse while in FIN
//   hi, lo   : architectural HI/LO registers
//   mf_data  : write-back value for mfhi/mflo (combinational)
// ---------------------------------------------------------------------------
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [5:0]  Funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;
    // acc[63:32] : product high half (mult) / partial remainder (div)
    // acc[31:0]  : multiplier being shifted out (mult) / dividend shifting
    //              out while quotient bits shift in (div)
    logic [63:0] acc_q,      acc_d;
    // multiplicand magnitude (mult) or divisor magnitude (div)
    logic [31:0] mag_b_q,    mag_b_d;
    logic        is_div_q,   is_div_d;
    logic        res_neg_q,  res_neg_d;   // product / quotient negative
    logic        rem_neg_q,  rem_neg_d;   // remainder takes dividend sign
    logic        div_zero_q, div_zero_d;
    logic [31:0] hi_q,       hi_d;
    logic [31:0] lo_q,       lo_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic dec_mfhi;
    logic dec_mthi;
    logic dec_mflo;
    logic dec_mtlo;
    logic dec_md;
    logic dec_any;

    assign dec_mfhi = valid && (Funct == F_MFHI);
    assign dec_mthi = valid && (Funct == F_MTHI);
    assign dec_mflo = valid && (Funct == F_MFLO);
    assign dec_mtlo = valid && (Funct == F_MTLO);
    assign dec_md   = valid && ((Funct == F_MULT) || (Funct == F_MULTU) ||
                                (Funct == F_DIV)  || (Funct == F_DIVU));
    assign dec_any  = dec_md || dec_mfhi || dec_mthi || dec_mflo || dec_mtlo;

    // -----------------------------------------------------------------------
    // Operand preparation for the accept cycle.
    // Funct[0]=0 selects the signed variant (mult, div); Funct[1]=1 selects
    // divide.
    // -----------------------------------------------------------------------
    logic        op_signed;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign op_signed = ~Funct[0];
    assign sign_a    = op_signed & rs_data[31];
    assign sign_b    = op_signed & rt_data[31];
    // 0x80000000 negates to itself, which is its correct unsigned magnitude
    assign mag_a     = sign_a ? (32'd0 - rs_data) : rs_data;
    assign mag_b     = sign_b ? (32'd0 - rt_data) : rt_data;

    // -----------------------------------------------------------------------
    // One shift-add multiply step: add the multiplicand into the high half
    // when the current multiplier LSB is set, then shift the 65-bit
    // {carry, acc} right by one.
    // -----------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_step;

    assign mul_sum  = {1'b0, acc_q[63:32]} +
                      (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
    assign mul_step = {mul_sum, acc_q[31:1]};

    // -----------------------------------------------------------------------
    // One restoring divide step: shift the next dividend bit into the
    // partial remainder, try subtracting the divisor, keep the difference
    // only when it did not go negative. The quotient bit enters at acc[0].
    // With a zero divisor every trial succeeds, so the quotient ends all
    // ones and the remainder ends equal to the dividend magnitude.
    // -----------------------------------------------------------------------
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_step;

    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};
    assign div_step  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0],  acc_q[30:0], 1'b1};

    // -----------------------------------------------------------------------
    // Sign application in FIN
    // -----------------------------------------------------------------------
    logic [63:0] prod_signed;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;

    assign prod_signed = res_neg_q ? (64'd0 - acc_q) : acc_q;
    assign quo_signed  = res_neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_signed  = rem_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mag_b_d    = mag_b_q;
        is_div_d   = is_div_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (dec_md) begin
                    state_d    = S_RUN;
                    cnt_d      = 6'd0;
                    acc_d      = {32'd0, mag_a};
                    mag_b_d    = mag_b;
                    is_div_d   = Funct[1];
                    res_neg_d  = sign_a ^ sign_b;
                    rem_neg_d  = sign_a;
                    div_zero_d = (rt_data == 32'd0);
                end else if (dec_mthi) begin
                    hi_d = rs_data;
                end else if (dec_mtlo) begin
                    lo_d = rs_data;
                end
            end

            S_RUN: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
                if (is_div_q) begin
                    // A zero divisor leaves the dividend magnitude in the
                    // remainder and rt's sign bit is 0, so rem_signed already
                    // reproduces rs_data; only LO needs forcing.
                    hi_d = rem_signed;
                    lo_d = div_zero_q ? 32'hFFFF_FFFF : quo_signed;
                end else begin
                    hi_d = prod_signed[63:32];
                    lo_d = prod_signed[31:0];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            acc_q      <= 64'd0;
            mag_b_q    <= 32'd0;
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mag_b_q    <= mag_b_d;
            is_div_q   <= is_div_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Gating with reset keeps stall low during reset even if valid/Funct
    // float around.
    assign stall   = reset && dec_any && (state_q != S_IDLE);
    assign mf_data = dec_mfhi ? hi_q : (dec_mflo ? lo_q : 32'd0);
    assign busy    = busy_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
